pc_counter: RTL and testbench

Parametrised, registered program counter for the Hack-style CPU datapath. It generalises the fixed 16-bit combinational incrementor to:
- configurable width and step;
- a runtime upper limit;
- up/down counting with wrap or saturate mode;
- a prioritised load/inc/dec/hold control set.

It sits in the fetch stage, driving the instruction-ROM address, and replaces the incrementor-plus-register pair.

---
 rtl/pc_counter_pkg.sv | 86 ++++++++
 rtl/pc_counter.sv | 56 +++++
 tb/tb_pc_counter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_counter_pkg.sv
// Shared definitions for pc_counter: control-priority codes and the widened
// next-value/wrap arithmetic shared by every counter width.
package pc_counter_pkg;

  // Arithmetic is done at this fixed width (+1 guard bit); supports WIDTH <= 64.
  localparam int PC_MAX_WIDTH = 64;

  typedef logic [PC_MAX_WIDTH:0] pc_wide_t;

  localparam logic [1:0] CTRL_HOLD = 2'd0;
  localparam logic [1:0] CTRL_LOAD = 2'd1;
  localparam logic [1:0] CTRL_INC  = 2'd2;
  localparam logic [1:0] CTRL_DEC  = 2'd3;

  typedef struct packed {
    pc_wide_t value;
    logic     wrap;
  } pc_next_t;

  // load beats everything; inc and dec together cancel into a hold.
  function automatic logic [1:0] pc_decode(input logic load, input logic inc, input logic dec);
    logic [1:0] ctrl;
    ctrl = CTRL_HOLD;
    if (load)
      ctrl = CTRL_LOAD;
    else if (inc && !dec)
      ctrl = CTRL_INC;
    else if (dec && !inc)
      ctrl = CTRL_DEC;
    return ctrl;
  endfunction

  // All operands are zero-extended, so limit + 1 and cur + step never overflow.
  function automatic pc_next_t pc_next(input logic [1:0] ctrl,
                                       input pc_wide_t   cur,
                                       input pc_wide_t   load_val,
                                       input pc_wide_t   limit,
                                       input pc_wide_t   step,
                                       input logic       saturate);
    pc_next_t r;
    pc_wide_t span;
    pc_wide_t sum;
    logic     can_wrap;
    r.value  = cur;
    r.wrap   = 1'b0;
    span     = limit + 1'b1;
    sum      = cur + step;
    can_wrap = !saturate && (step <= span);
    case (ctrl)
      CTRL_LOAD: begin
        r.value = (load_val > limit) ? limit : load_val;
      end
      CTRL_INC: begin
        if (cur > limit) begin
          r.value = limit;
        end else if (sum <= limit) begin
          r.value = sum;
        end else if (can_wrap) begin
          r.value = sum - span;
          r.wrap  = 1'b1;
        end else begin
          r.value = limit;
          r.wrap  = (cur < limit);
        end
      end
      CTRL_DEC: begin
        if (cur > limit) begin
          r.value = limit;
        end else if (cur >= step) begin
          r.value = cur - step;
        end else if (can_wrap) begin
          r.value = cur + span - step;
          r.wrap  = 1'b1;
        end else begin
          r.value = '0;
          r.wrap  = (cur != '0);
        end
      end
      default: begin
        r.value = cur;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Registered program counter with load/inc/dec priority, runtime upper limit
// and wrap-or-saturate behaviour; drives the instruction-ROM address.
module pc_counter
  import pc_counter_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] STEP      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_max
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [1:0]       ctrl;
  pc_next_t         nxt;
  logic             unused_next_hi;

  always_comb begin
    ctrl      = pc_decode(load, inc, dec);
    nxt       = pc_next(ctrl, pc_wide_t'(out_reg), pc_wide_t'(in), pc_wide_t'(limit),
                        pc_wide_t'(STEP), SATURATE);
    out_next  = nxt.value[WIDTH-1:0];
    wrap_next = nxt.wrap;
  end

  // Results never exceed limit or the old count, so the guard bits are always zero.
  assign unused_next_hi = ^nxt.value[PC_MAX_WIDTH:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg  <= RESET_VAL;
      wrap_reg <= 1'b0;
    end else begin
      out_reg  <= out_next;
      wrap_reg <= wrap_next;
    end
  end

  assign out    = out_reg;
  assign wrap   = wrap_reg;
  assign at_max = (out_reg == limit);

endmodule

// File: tb/tb_pc_counter.sv
// Drives three pc_counter variants from shared stimulus and checks them each
// cycle against an arithmetic model, plus literal spot checks.
module tb_pc_counter;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        inc;
  logic        dec;
  logic [15:0] in_val;
  logic [15:0] limit;
  logic [15:0] dut_out  [3];
  logic        dut_wrap [3];
  logic        dut_max  [3];

  int n_cmp = 0;
  int n_bad = 0;

  longint m_step [3] = '{1, 3, 4};
  bit     m_sat  [3] = '{1'b0, 1'b0, 1'b1};
  longint m_rv   [3] = '{0, 0, 12};
  longint m_out  [3];
  bit     m_wrap [3];
  bit     model_valid = 1'b0;

  pc_counter #(.WIDTH(16), .STEP(16'd1), .RESET_VAL(16'd0), .SATURATE(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_val),
    .limit(limit), .out(dut_out[0]), .wrap(dut_wrap[0]), .at_max(dut_max[0]));

  pc_counter #(.WIDTH(16), .STEP(16'd3), .RESET_VAL(16'd0), .SATURATE(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_val),
    .limit(limit), .out(dut_out[1]), .wrap(dut_wrap[1]), .at_max(dut_max[1]));

  pc_counter #(.WIDTH(16), .STEP(16'd4), .RESET_VAL(16'd12), .SATURATE(1'b1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .dec(dec), .in(in_val),
    .limit(limit), .out(dut_out[2]), .wrap(dut_wrap[2]), .at_max(dut_max[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counting range is 0..limit, i.e. limit+1 values.
  task automatic model_step(input int k);
    longint lim, span, cur, nxt;
    bit     w;
    lim  = longint'(limit);
    span = lim + 1;
    cur  = m_out[k];
    nxt  = cur;
    w    = 1'b0;
    if (!rst_n) begin
      nxt = m_rv[k];
    end else if (load) begin
      nxt = (longint'(in_val) < lim) ? longint'(in_val) : lim;
    end else if (inc == dec) begin
      nxt = cur;
    end else if (cur > lim) begin
      nxt = lim;
    end else if (inc) begin
      if (cur + m_step[k] <= lim) begin
        nxt = cur + m_step[k];
      end else if (!m_sat[k] && m_step[k] <= span) begin
        nxt = cur + m_step[k] - span;
        w   = 1'b1;
      end else begin
        nxt = lim;
        w   = (cur < lim);
      end
    end else begin
      if (cur >= m_step[k]) begin
        nxt = cur - m_step[k];
      end else if (!m_sat[k] && m_step[k] <= span) begin
        nxt = cur + span - m_step[k];
        w   = 1'b1;
      end else begin
        nxt = 0;
        w   = (cur > 0);
      end
    end
    m_out[k]  = nxt;
    m_wrap[k] = w;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
    if (!rst_n) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_out[%0d]", k), 64'(dut_out[k]), 64'(m_out[k]));
        chk($sformatf("model_wrap[%0d]", k), 64'(dut_wrap[k]), 64'(m_wrap[k]));
        chk($sformatf("model_at_max[%0d]", k), 64'(dut_max[k]),
            64'(m_out[k] == longint'(limit)));
      end
    end
  end

  task automatic cyc(input logic r, input logic ld, input logic ic, input logic dc,
                     input logic [15:0] v, input logic [15:0] lim);
    rst_n  = r;
    load   = ld;
    inc    = ic;
    dec    = dc;
    in_val = v;
    limit  = lim;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rlim;
    // Reset and basic increment
    cyc(0, 0, 0, 0, 16'd0, 16'hFFFF);
    cyc(0, 0, 0, 0, 16'd0, 16'hFFFF);
    chk("reset_out_d1", 64'(dut_out[0]), 64'd0);
    chk("reset_wrap_d1", 64'(dut_wrap[0]), 64'd0);
    chk("reset_out_d4", 64'(dut_out[2]), 64'd12);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 1, 0, 16'd0, 16'hFFFF);
      chk($sformatf("inc_out_%0d", i), 64'(dut_out[0]), 64'(i));
      chk($sformatf("inc_wrap_%0d", i), 64'(dut_wrap[0]), 64'd0);
    end
    // Wrap up and down, STEP=3, limit=10
    cyc(1, 1, 0, 0, 16'd9, 16'd10);
    chk("wrap_load9", 64'(dut_out[1]), 64'd9);
    cyc(1, 0, 1, 0, 16'd0, 16'd10);
    chk("wrap_up_out", 64'(dut_out[1]), 64'd1);
    chk("wrap_up_flag", 64'(dut_wrap[1]), 64'd1);
    chk("wrap_up_at_max", 64'(dut_max[1]), 64'd0);
    cyc(1, 0, 0, 0, 16'd0, 16'd10);
    chk("wrap_one_cycle", 64'(dut_wrap[1]), 64'd0);
    cyc(1, 0, 0, 1, 16'd0, 16'd10);
    chk("wrap_dn_out", 64'(dut_out[1]), 64'd9);
    chk("wrap_dn_flag", 64'(dut_wrap[1]), 64'd1);
    cyc(1, 1, 0, 0, 16'd10, 16'd10);
    chk("at_max_10", 64'(dut_max[1]), 64'd1);
    // Saturate, STEP=4, limit=10
    cyc(1, 1, 0, 0, 16'd8, 16'd10);
    cyc(1, 0, 1, 0, 16'd0, 16'd10);
    chk("sat_inc1_out", 64'(dut_out[2]), 64'd10);
    chk("sat_inc1_wrap", 64'(dut_wrap[2]), 64'd1);
    cyc(1, 0, 1, 0, 16'd0, 16'd10);
    chk("sat_inc2_out", 64'(dut_out[2]), 64'd10);
    chk("sat_inc2_wrap", 64'(dut_wrap[2]), 64'd0);
    cyc(1, 1, 0, 0, 16'd2, 16'd10);
    cyc(1, 0, 0, 1, 16'd0, 16'd10);
    chk("sat_dec_out", 64'(dut_out[2]), 64'd0);
    chk("sat_dec_wrap", 64'(dut_wrap[2]), 64'd1);
    // Priority
    cyc(1, 1, 1, 1, 16'd7, 16'hFFFF);
    chk("prio_load", 64'(dut_out[0]), 64'd7);
    cyc(1, 0, 1, 1, 16'd0, 16'hFFFF);
    chk("prio_hold", 64'(dut_out[1]), 64'd7);
    cyc(1, 1, 0, 0, 16'd200, 16'd50);
    chk("load_clamp", 64'(dut_out[0]), 64'd50);
    // Limit lowered, then reset mid-count
    cyc(1, 1, 0, 0, 16'd40, 16'd50);
    cyc(1, 0, 0, 0, 16'd0, 16'd20);
    chk("oor_hold", 64'(dut_out[0]), 64'd40);
    cyc(1, 0, 1, 0, 16'd0, 16'd20);
    chk("oor_inc_out", 64'(dut_out[1]), 64'd20);
    chk("oor_inc_wrap", 64'(dut_wrap[1]), 64'd0);
    cyc(0, 0, 1, 0, 16'd0, 16'd20);
    chk("midrst_out_d4", 64'(dut_out[2]), 64'd12);
    chk("midrst_wrap_d4", 64'(dut_wrap[2]), 64'd0);
    // Full-range modulo
    cyc(1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
    cyc(1, 0, 1, 0, 16'd0, 16'hFFFF);
    chk("full_inc_out", 64'(dut_out[0]), 64'd0);
    chk("full_inc_wrap", 64'(dut_wrap[0]), 64'd1);
    chk("full_inc_d3", 64'(dut_out[1]), 64'd2);
    cyc(1, 0, 0, 1, 16'd0, 16'hFFFF);
    chk("full_dec_out", 64'(dut_out[0]), 64'hFFFF);
    chk("full_dec_wrap", 64'(dut_wrap[0]), 64'd1);
    // Randomized traffic, checked by the per-cycle compare
    rlim = 16'd10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0:       rlim = 16'hFFFF;
          1:       rlim = 16'($urandom_range(0, 20));
          default: rlim = 16'($urandom);
        endcase
      end
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 30)) : 16'($urandom), rlim);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
